// File: rtl/lenet_prod_accum.sv
// Sums a stream of unsigned multiplier products onto a bias and presents one result per vector.
// Result valid the cycle after the terminating beat; input stalls while a result is held unread.
module lenet_prod_accum #(
    parameter int PROD_W  = 16,
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 25,
    parameter int SAT     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PROD_W-1:0]            in_prod,
    input  logic                         in_last,
    input  logic [ACC_W-1:0]             in_bias,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_acc,
    output logic [$clog2(MAX_LEN+1)-1:0] out_cnt,
    output logic                         out_ovf,
    output logic                         out_lenerr
);

    localparam int CNT_W = $clog2(MAX_LEN+1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_lenerr;

    logic               w_first;
    logic               w_beat;
    logic               w_take;
    logic [ACC_W-1:0]   w_base;
    logic [ACC_W:0]     w_sum;
    logic               w_carry;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_at_max;
    logic               w_term;
    logic               w_ovf_nxt;
    logic               w_lenerr_nxt;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign w_first = (r_state == S_IDLE);
    assign w_beat  = in_valid & in_ready;
    assign w_take  = (r_state == S_HOLD) & out_ready;

    // Bias replaces the running sum on the first beat of a vector.
    assign w_base  = w_first ? in_bias : r_acc;
    assign w_sum   = {1'b0, w_base} + {{(ACC_W+1-PROD_W){1'b0}}, in_prod};
    assign w_carry = w_sum[ACC_W];

    always_comb begin
        w_acc_nxt = w_sum[ACC_W-1:0];
        if (w_carry && (SAT != 0)) begin
            w_acc_nxt = {ACC_W{1'b1}};
        end
    end

    assign w_cnt_nxt    = w_first ? CNT_W'(1) : (r_cnt + CNT_W'(1));
    assign w_at_max     = (w_cnt_nxt == CNT_W'(MAX_LEN));
    assign w_term       = in_last | w_at_max;
    assign w_ovf_nxt    = (w_first ? 1'b0 : r_ovf) | w_carry;
    assign w_lenerr_nxt = w_at_max & ~in_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_lenerr <= 1'b0;
        end else if (w_beat) begin
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ovf    <= w_ovf_nxt;
            r_lenerr <= w_lenerr_nxt;
        end else if (w_take) begin
            // acc is left as-is; the next first beat overwrites it with the bias.
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_lenerr <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_beat) begin
                    w_state_nxt = w_term ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_beat && w_term) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (r_state)
            S_HOLD: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
        endcase
    end

    assign out_acc    = r_acc;
    assign out_cnt    = r_cnt;
    assign out_ovf    = r_ovf;
    assign out_lenerr = r_lenerr;

endmodule

// File: tb/tb_lenet_prod_accum.sv
// Directed and randomised checks of lenet_prod_accum: default build plus 17-bit saturating and wrapping builds.
module tb_lenet_prod_accum;

    logic clk;
    logic rst_n;

    // default build: PROD_W=16, ACC_W=24, MAX_LEN=25, SAT=1
    logic        m_in_valid, m_in_ready, m_in_last, m_out_valid, m_out_ready, m_out_ovf, m_out_lenerr;
    logic [15:0] m_in_prod;
    logic [23:0] m_in_bias, m_out_acc;
    logic [4:0]  m_out_cnt;

    // shared stimulus for the two 17-bit builds
    logic        s_in_valid, s_in_last, s_out_ready;
    logic [15:0] s_in_prod;
    logic [16:0] s_in_bias;

    logic        a_in_ready, a_out_valid, a_out_ovf, a_out_lenerr;
    logic [16:0] a_out_acc;
    logic [4:0]  a_out_cnt;
    logic        w_in_ready, w_out_valid, w_out_ovf, w_out_lenerr;
    logic [16:0] w_out_acc;
    logic [4:0]  w_out_cnt;

    int checks = 0;
    int errors = 0;

    lenet_prod_accum u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_prod(m_in_prod),
        .in_last(m_in_last), .in_bias(m_in_bias),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_acc(m_out_acc),
        .out_cnt(m_out_cnt), .out_ovf(m_out_ovf), .out_lenerr(m_out_lenerr)
    );

    lenet_prod_accum #(.PROD_W(16), .ACC_W(17), .MAX_LEN(25), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(a_in_ready), .in_prod(s_in_prod),
        .in_last(s_in_last), .in_bias(s_in_bias),
        .out_valid(a_out_valid), .out_ready(s_out_ready), .out_acc(a_out_acc),
        .out_cnt(a_out_cnt), .out_ovf(a_out_ovf), .out_lenerr(a_out_lenerr)
    );

    lenet_prod_accum #(.PROD_W(16), .ACC_W(17), .MAX_LEN(25), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(w_in_ready), .in_prod(s_in_prod),
        .in_last(s_in_last), .in_bias(s_in_bias),
        .out_valid(w_out_valid), .out_ready(s_out_ready), .out_acc(w_out_acc),
        .out_cnt(w_out_cnt), .out_ovf(w_out_ovf), .out_lenerr(w_out_lenerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one beat on the default build, holds it until accepted, returns at the following negedge.
    task automatic m_beat(input logic [15:0] p, input logic l, input logic [23:0] b, input int gap);
        int w;
        for (int g = 0; g < gap; g++) @(negedge clk);
        m_in_valid = 1'b1; m_in_prod = p; m_in_last = l; m_in_bias = b;
        w = 0;
        while (!m_in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!m_in_ready) chk("m_ready_timeout", {31'd0, m_in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        m_in_valid = 1'b0;
    endtask

    task automatic s_beat(input logic [15:0] p, input logic l, input logic [16:0] b);
        int w;
        s_in_valid = 1'b1; s_in_prod = p; s_in_last = l; s_in_bias = b;
        w = 0;
        while (!a_in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!a_in_ready) chk("s_ready_timeout", {31'd0, a_in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        s_in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] prods [$];
        logic [23:0] bias;
        logic [24:0] gsum;
        logic        govf;
        int          len, hold_rdy, dly;

        rst_n = 1'b0;
        m_in_valid = 1'b0; m_in_prod = '0; m_in_last = 1'b0; m_in_bias = '0; m_out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_prod = '0; s_in_last = 1'b0; s_in_bias = '0; s_out_ready = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_in_ready",  {31'd0, m_in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, m_out_valid}, 32'd0);
        chk("rst_out_acc",   {8'd0, m_out_acc},    32'd0);
        chk("rst_out_cnt",   {27'd0, m_out_cnt},   32'd0);
        chk("rst_out_ovf",   {31'd0, m_out_ovf},   32'd0);
        chk("rst_lenerr",    {31'd0, m_out_lenerr}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic three-beat vector, consumer always ready
        m_beat(16'd100, 1'b0, 24'd10, 0);
        m_beat(16'd200, 1'b0, 24'd999, 0);
        chk("t1_not_yet_valid", {31'd0, m_out_valid}, 32'd0);
        m_beat(16'd300, 1'b1, 24'd999, 0);
        chk("t1_out_valid", {31'd0, m_out_valid}, 32'd1);
        chk("t1_acc",       {8'd0, m_out_acc},    32'd610);
        chk("t1_cnt",       {27'd0, m_out_cnt},   32'd3);
        chk("t1_ovf",       {31'd0, m_out_ovf},   32'd0);
        chk("t1_lenerr",    {31'd0, m_out_lenerr}, 32'd0);
        @(negedge clk);
        chk("t1_released", {31'd0, m_out_valid}, 32'd0);
        chk("t1_in_ready", {31'd0, m_in_ready},  32'd1);

        // back-pressure: result held, a pending beat is not accepted, no same-cycle restart
        m_out_ready = 1'b0;
        m_beat(16'd100, 1'b0, 24'd10, 0);
        m_beat(16'd200, 1'b0, 24'd0, 0);
        m_beat(16'd300, 1'b1, 24'd0, 0);
        m_in_valid = 1'b1; m_in_prod = 16'd5; m_in_last = 1'b1; m_in_bias = 24'd1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid",    {31'd0, m_out_valid}, 32'd1);
            chk("t2_hold_in_ready", {31'd0, m_in_ready},  32'd0);
            chk("t2_hold_acc",      {8'd0, m_out_acc},    32'd610);
            chk("t2_hold_cnt",      {27'd0, m_out_cnt},   32'd3);
            @(negedge clk);
        end
        m_out_ready = 1'b1;
        @(negedge clk);
        chk("t2_idle_valid", {31'd0, m_out_valid}, 32'd0);
        chk("t2_idle_ready", {31'd0, m_in_ready},  32'd1);
        chk("t2_idle_cnt",   {27'd0, m_out_cnt},   32'd0);
        @(negedge clk);
        m_in_valid = 1'b0;
        chk("t2_next_valid", {31'd0, m_out_valid}, 32'd1);
        chk("t2_next_acc",   {8'd0, m_out_acc},    32'd6);
        chk("t2_next_cnt",   {27'd0, m_out_cnt},   32'd1);
        @(negedge clk);

        // 17-bit saturate vs wrap, then ovf must not carry into the next vector
        s_beat(16'h0020, 1'b0, 17'h1FFF0);
        s_beat(16'h0005, 1'b1, 17'h0);
        chk("t3_sat_valid",  {31'd0, a_out_valid}, 32'd1);
        chk("t3_sat_acc",    {15'd0, a_out_acc},   32'h1FFFF);
        chk("t3_sat_ovf",    {31'd0, a_out_ovf},   32'd1);
        chk("t3_sat_cnt",    {27'd0, a_out_cnt},   32'd2);
        chk("t3_wrap_acc",   {15'd0, w_out_acc},   32'h00015);
        chk("t3_wrap_ovf",   {31'd0, w_out_ovf},   32'd1);
        @(negedge clk);
        s_beat(16'd2, 1'b1, 17'd1);
        chk("t3_sat_clr_acc",  {15'd0, a_out_acc}, 32'd3);
        chk("t3_sat_clr_ovf",  {31'd0, a_out_ovf}, 32'd0);
        chk("t3_wrap_clr_ovf", {31'd0, w_out_ovf}, 32'd0);
        @(negedge clk);

        // length limit: 25 beats without last
        for (int i = 0; i < 24; i++) m_beat(16'hFFFF, 1'b0, 24'd100, 0);
        chk("t4_24_not_valid", {31'd0, m_out_valid}, 32'd0);
        m_beat(16'hFFFF, 1'b0, 24'd100, 0);
        chk("t4_valid",  {31'd0, m_out_valid},  32'd1);
        chk("t4_cnt",    {27'd0, m_out_cnt},    32'd25);
        chk("t4_acc",    {8'd0, m_out_acc},     32'd1638475);
        chk("t4_lenerr", {31'd0, m_out_lenerr}, 32'd1);
        chk("t4_ovf",    {31'd0, m_out_ovf},    32'd0);
        @(negedge clk);
        m_beat(16'd9, 1'b1, 24'd4, 0);
        chk("t4_new_acc",    {8'd0, m_out_acc},     32'd13);
        chk("t4_new_cnt",    {27'd0, m_out_cnt},    32'd1);
        chk("t4_new_lenerr", {31'd0, m_out_lenerr}, 32'd0);
        @(negedge clk);

        // reset mid-vector discards the partial sum
        m_beat(16'd3, 1'b0, 24'd50, 0);
        m_beat(16'd8, 1'b0, 24'd0, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, m_out_valid}, 32'd0);
        chk("t5_rst_ready", {31'd0, m_in_ready},  32'd1);
        chk("t5_rst_acc",   {8'd0, m_out_acc},    32'd0);
        chk("t5_rst_cnt",   {27'd0, m_out_cnt},   32'd0);
        @(negedge clk);
        chk("t5_rst_valid2", {31'd0, m_out_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        m_beat(16'd7, 1'b1, 24'd20, 0);
        chk("t5_acc", {8'd0, m_out_acc},  32'd27);
        chk("t5_cnt", {27'd0, m_out_cnt}, 32'd1);
        @(negedge clk);

        // random vectors against a saturating golden sum
        for (int v = 0; v < 30; v++) begin
            len  = $urandom_range(1, 25);
            bias = 24'($urandom);
            if ($urandom_range(0, 2) != 0) bias = bias >> 4;
            prods.delete();
            for (int k = 0; k < len; k++) prods.push_back(16'($urandom));
            gsum = {1'b0, bias};
            govf = 1'b0;
            foreach (prods[k]) begin
                gsum = gsum + {9'd0, prods[k]};
                if (gsum > 25'hFFFFFF) begin
                    gsum = 25'hFFFFFF;
                    govf = 1'b1;
                end
            end
            hold_rdy = $urandom_range(0, 1);
            m_out_ready = (hold_rdy == 1);
            for (int k = 0; k < len; k++)
                m_beat(prods[k], (k == len - 1), (k == 0) ? bias : 24'($urandom), $urandom_range(0, 2));
            chk("r_valid",  {31'd0, m_out_valid},  32'd1);
            chk("r_acc",    {8'd0, m_out_acc},     {8'd0, gsum[23:0]});
            chk("r_cnt",    {27'd0, m_out_cnt},    32'(len));
            chk("r_ovf",    {31'd0, m_out_ovf},    {31'd0, govf});
            chk("r_lenerr", {31'd0, m_out_lenerr}, 32'd0);
            if (hold_rdy == 0) begin
                dly = $urandom_range(0, 3);
                for (int d = 0; d < dly; d++) begin
                    @(negedge clk);
                    chk("r_hold_acc", {8'd0, m_out_acc}, {8'd0, gsum[23:0]});
                end
                m_out_ready = 1'b1;
            end
            @(negedge clk);
            chk("r_released", {31'd0, m_out_valid}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
